mul_unit: RTL and testbench

- Iterative radix-2 shift-add multiplier for the RV32M multiply group: MUL, MULH, MULHSU, MULHU.
- Sits in the EX stage and consumes the 4-bit ALUOp multiply codes emitted by the decode stage.
- Holds the pipeline through a stall request while the multiply runs, then returns a 32-bit result for writeback with a one-cycle done strobe.

---
 rtl/mul_unit.sv | 134 +++++++++++++
 tb/tb_mul_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit.sv
// mul_unit: iterative radix-2 shift-add multiplier for the RV32M multiply group
// (MUL, MULH, MULHSU, MULHU). Operands are reduced to magnitudes at accept time,
// multiplied over XLEN steps, and the product is re-signed on the final step so
// the result register is valid in the single DONE cycle.
module mul_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic            stall_req
);

    // ALUOp multiply codes produced by the decode stage
    localparam logic [3:0] MUL_OP_MUL    = 4'b1010;
    localparam logic [3:0] MUL_OP_MULH   = 4'b1011;
    localparam logic [3:0] MUL_OP_MULHSU = 4'b1100;
    localparam logic [3:0] MUL_OP_MULHU  = 4'b1101;

    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [3:0]            r_op;
    logic                  r_neg;
    logic [2*XLEN-1:0]     r_multiplicand;
    logic [XLEN-1:0]       r_multiplier;
    logic [2*XLEN-1:0]     r_acc;
    logic [CW-1:0]         r_count;
    logic [XLEN-1:0]       r_result;

    logic                  w_is_mul;
    logic                  w_accept;
    logic                  w_last_step;
    logic                  w_a_neg;
    logic                  w_b_neg;
    logic [XLEN-1:0]       w_a_mag;
    logic [XLEN-1:0]       w_b_mag;
    logic [2*XLEN-1:0]     w_acc_step;
    logic [2*XLEN-1:0]     w_product;
    logic [XLEN-1:0]       w_result_sel;

    assign w_is_mul = (op == MUL_OP_MUL) || (op == MUL_OP_MULH) ||
                      (op == MUL_OP_MULHSU) || (op == MUL_OP_MULHU);

    // flush wins over a simultaneous start
    assign w_accept    = (r_state == S_IDLE) && start && w_is_mul && !flush;
    assign w_last_step = (r_count == CW'(XLEN - 1));

    // Operand a is signed except for MULHU; operand b only for MUL/MULH.
    // The most-negative value negates to itself, which is its correct magnitude.
    assign w_a_neg = rs1_data[XLEN-1] && (op != MUL_OP_MULHU);
    assign w_b_neg = rs2_data[XLEN-1] && ((op == MUL_OP_MUL) || (op == MUL_OP_MULH));
    assign w_a_mag = w_a_neg ? (~rs1_data + 1'b1) : rs1_data;
    assign w_b_mag = w_b_neg ? (~rs2_data + 1'b1) : rs2_data;

    // One shift-add step; on the last step this is the full unsigned product
    assign w_acc_step   = r_multiplier[0] ? (r_acc + r_multiplicand) : r_acc;
    assign w_product    = r_neg ? (~w_acc_step + 1'b1) : w_acc_step;
    assign w_result_sel = (r_op == MUL_OP_MUL) ? w_product[XLEN-1:0]
                                               : w_product[2*XLEN-1:XLEN];

    assign stall_req = ((r_state == S_IDLE) && start && w_is_mul) || (r_state == S_CALC);
    assign busy      = (r_state == S_CALC) || (r_state == S_DONE);
    assign done      = (r_state == S_DONE);
    assign result    = r_result;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: IDLE -> CALC on accept, CALC -> DONE after XLEN steps,
    // DONE -> IDLE unconditionally; flush returns to IDLE from anywhere
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_CALC;
            S_CALC:  if (w_last_step) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (flush) begin
            w_state_next = S_IDLE;
        end
    end

    // Datapath: latch operands on accept, step in CALC, load result on the final step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op           <= 4'd0;
            r_neg          <= 1'b0;
            r_multiplicand <= '0;
            r_multiplier   <= '0;
            r_acc          <= '0;
            r_count        <= '0;
            r_result       <= '0;
        end else if (w_accept) begin
            r_op           <= op;
            r_neg          <= w_a_neg ^ w_b_neg;
            r_multiplicand <= {{XLEN{1'b0}}, w_a_mag};
            r_multiplier   <= w_b_mag;
            r_acc          <= '0;
            r_count        <= '0;
        end else if ((r_state == S_CALC) && !flush) begin
            r_acc          <= w_acc_step;
            r_multiplicand <= r_multiplicand << 1;
            r_multiplier   <= r_multiplier >> 1;
            r_count        <= r_count + 1'b1;
            if (w_last_step) begin
                r_result <= w_result_sel;
            end
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Directed testbench for mul_unit: arithmetic vectors, latency, abort paths and
// ignored requests, all checked against hand-computed values.
module tb_mul_unit;

    localparam logic [3:0] OP_MUL    = 4'b1010;
    localparam logic [3:0] OP_MULH   = 4'b1011;
    localparam logic [3:0] OP_MULHSU = 4'b1100;
    localparam logic [3:0] OP_MULHU  = 4'b1101;
    localparam logic [3:0] OP_ADD    = 4'b0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        stall_req;

    int tests = 0;
    int fails = 0;

    logic [31:0] res;
    int          lat;
    int          stalls;
    int          dones;

    mul_unit #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op        (op),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, then watch 40 cycles after the accept edge.
    // k counts edges since the accept edge; sampling is 1 ns after each edge.
    task automatic do_mul(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output int l, output int s, output int d);
        @(posedge clk); #1;
        start = 1'b1; op = o; rs1_data = a; rs2_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = OP_ADD; rs1_data = $urandom; rs2_data = $urandom;
        r = '0; l = -1; s = 0; d = 0;
        for (int k = 0; k < 40; k++) begin
            if (stall_req) s++;
            if (done) begin
                d++;
                if (l < 0) begin
                    l = k;
                    r = result;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = OP_ADD; rs1_data = '0; rs2_data = '0; flush = 1'b0;
        #12;
        check("reset_busy",   {31'd0, busy},      32'd0);
        check("reset_done",   {31'd0, done},      32'd0);
        check("reset_result", result,             32'd0);
        check("reset_stall",  {31'd0, stall_req}, 32'd0);
        rst_n = 1'b1;

        // stall_req is combinational on a valid request in IDLE
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; rs1_data = 32'd7; rs2_data = 32'd6;
        #1;
        check("req_stall_comb", {31'd0, stall_req}, 32'd1);
        start = 1'b0;

        do_mul(OP_MUL, 32'd7, 32'd6, res, lat, stalls, dones);
        $display("[TB] MUL 7*6 result=%h latency=%0d stalls=%0d dones=%0d", res, lat, stalls, dones);
        check("mul_7x6",        res,    32'h0000002A);
        check("mul_latency",    lat,    32'd32);
        check("mul_stall_cnt",  stalls, 32'd32);
        check("mul_done_cnt",   dones,  32'd1);
        check("mul_hold",       result, 32'h0000002A);

        do_mul(OP_MUL, 32'hFFFFFFFD, 32'd5, res, lat, stalls, dones);
        $display("[TB] MUL -3*5 result=%h", res);
        check("mul_neg3x5", res, 32'hFFFFFFF1);

        do_mul(OP_MULH, 32'hFFFFFFFD, 32'd5, res, lat, stalls, dones);
        $display("[TB] MULH -3*5 result=%h", res);
        check("mulh_neg3x5", res, 32'hFFFFFFFF);

        do_mul(OP_MULH, 32'h80000000, 32'h80000000, res, lat, stalls, dones);
        $display("[TB] MULH min*min result=%h", res);
        check("mulh_min_min", res, 32'h40000000);

        do_mul(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, stalls, dones);
        $display("[TB] MULHU max*max result=%h", res);
        check("mulhu_max_max", res, 32'hFFFFFFFE);

        do_mul(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, res, lat, stalls, dones);
        $display("[TB] MULHSU -1*max result=%h", res);
        check("mulhsu_m1_max", res, 32'hFFFFFFFF);

        do_mul(OP_MUL, 32'h80000000, 32'hFFFFFFFF, res, lat, stalls, dones);
        $display("[TB] MUL min*-1 result=%h", res);
        check("mul_min_m1", res, 32'h80000000);

        // Flush at count=10: back to IDLE on the next edge, no done afterwards
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; rs1_data = 32'd9; rs2_data = 32'd9;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        $display("[TB] flush at count 10: busy=%b stall=%b done=%b", busy, stall_req, done);
        check("flush_busy",  {31'd0, busy},      32'd0);
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("flush_no_done",  dones,  32'd0);
        check("flush_res_kept", result, 32'h80000000);

        // Flush and start together: stall still follows the equation, no accept
        start = 1'b1; flush = 1'b1; op = OP_MUL; rs1_data = 32'd2; rs2_data = 32'd2;
        #1;
        check("flush_start_stall", {31'd0, stall_req}, 32'd1);
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        $display("[TB] flush+start: busy=%b", busy);
        check("flush_start_busy", {31'd0, busy}, 32'd0);

        // Reset at count=20: outputs clear at once, no done afterwards
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; rs1_data = 32'd11; rs2_data = 32'd13;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        $display("[TB] reset at count 20: busy=%b done=%b result=%h stall=%b", busy, done, result, stall_req);
        check("rst_busy",   {31'd0, busy},      32'd0);
        check("rst_result", result,             32'd0);
        check("rst_stall",  {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 40; k++) begin
            if (done) dones++;
            @(posedge clk); #1;
        end
        check("rst_no_done", dones, 32'd0);

        do_mul(OP_MUL, 32'd3, 32'd4, res, lat, stalls, dones);
        $display("[TB] MUL 3*4 after abort result=%h", res);
        check("mul_3x4", res, 32'h0000000C);

        // Non-multiply op: no stall, no activity
        start = 1'b1; op = OP_ADD; rs1_data = 32'd1; rs2_data = 32'd1;
        #1;
        check("add_no_stall", {31'd0, stall_req}, 32'd0);
        dones = 0; stalls = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (done || busy) dones++;
            if (stall_req) stalls++;
        end
        start = 1'b0;
        $display("[TB] ADD request: activity=%0d stalls=%0d", dones, stalls);
        check("add_no_busy",   dones,  32'd0);
        check("add_no_stall2", stalls, 32'd0);

        // Start pulses during CALC and DONE are ignored
        @(posedge clk); #1;
        start = 1'b1; op = OP_MUL; rs1_data = 32'd7; rs2_data = 32'd6;
        @(posedge clk); #1;
        rs1_data = 32'd100; rs2_data = 32'd100;
        dones = 0; res = '0;
        for (int k = 0; k < 40; k++) begin
            if (k == 33) start = 1'b0;
            if (done) begin
                dones++;
                res = result;
            end
            @(posedge clk); #1;
        end
        $display("[TB] start held during CALC: dones=%0d result=%h busy=%b", dones, res, busy);
        check("ign_done_cnt", dones, 32'd1);
        check("ign_result",   res,   32'h0000002A);
        check("ign_idle",     {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
